// File: rtl/cu_if.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack handshake, hands words to decode.
// Define IFU_FETCH_COUNT_EN to build the issued-instruction counter on fetch_count.
module cu_if #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        soc_clk,
  input  logic        IFU_reset,
  input  logic        fetch_enable,
  input  logic        IFU_stall,
  input  logic        pc_advance,
  input  logic [31:0] pc_increment,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic        Fetch_ready,
  output logic [31:0] pc,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {IDLE, MEM, ISSUE, WAIT, FAULT} state_t;

  localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0]  CAUSE_TIMEOUT  = 2'b10;
  localparam logic [31:0] TIMEOUT_LIMIT  = ACK_TIMEOUT;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] target_q;
  logic [31:0] timeoutCnt_q;
  logic        discard_q;
  logic        fault_q;
  logic [1:0]  cause_q;

  logic [31:0] nextPc_d;
  logic        nextValid_d;
  logic        timeoutHit_d;

  // Redirect beats a sequential advance; an advance under stall is simply dropped.
  always_comb begin
    nextPc_d     = pc_q + pc_increment;
    nextValid_d  = pc_advance && !IFU_stall;
    if (redirect) begin
      nextPc_d    = redirect_target;
      nextValid_d = 1'b1;
    end
    timeoutHit_d = (TIMEOUT_LIMIT != 32'd0) && ((timeoutCnt_q + 32'd1) == TIMEOUT_LIMIT);
  end

  always_ff @(posedge soc_clk or negedge IFU_reset) begin
    if (!IFU_reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= 32'd0;
      target_q     <= 32'd0;
      timeoutCnt_q <= 32'd0;
      discard_q    <= 1'b0;
      fault_q      <= 1'b0;
      cause_q      <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_enable) begin
            if (pc_q[1:0] != 2'b00) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
              cause_q <= CAUSE_MISALIGN;
            end else begin
              state_q <= MEM;
            end
          end
        end
        MEM: begin
          // Any ack ends this request; stale data from before a redirect is dropped and re-requested.
          if (mem_ack) begin
            timeoutCnt_q <= 32'd0;
            if (redirect) begin
              pc_q      <= redirect_target;
              discard_q <= 1'b0;
            end else if (discard_q) begin
              pc_q      <= target_q;
              discard_q <= 1'b0;
            end else begin
              instr_q <= mem_rdata;
              state_q <= ISSUE;
            end
          end else if (timeoutHit_d) begin
            timeoutCnt_q <= 32'd0;
            state_q      <= FAULT;
            fault_q      <= 1'b1;
            cause_q      <= CAUSE_TIMEOUT;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 32'd1;
            if (redirect) begin
              target_q  <= redirect_target;
              discard_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (redirect) begin
            pc_q    <= redirect_target;
            state_q <= MEM;
          end else if (!IFU_stall) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (nextValid_d) begin
            pc_q <= nextPc_d;
            if (nextPc_d[1:0] != 2'b00) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
              cause_q <= CAUSE_MISALIGN;
            end else begin
              state_q <= MEM;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_req     = (state_q == MEM);
  assign Fetch_ready = (state_q == ISSUE);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign fetch_fault = fault_q;
  assign fault_cause = cause_q;

`ifdef IFU_FETCH_COUNT_EN
  logic [31:0] fetchCount_q;

  // Counts only the accepting ack, so stalls and discarded words never add to it.
  always_ff @(posedge soc_clk or negedge IFU_reset) begin
    if (!IFU_reset) begin
      fetchCount_q <= 32'd0;
    end else if (state_q == MEM && mem_ack && !redirect && !discard_q) begin
      fetchCount_q <= fetchCount_q + 32'd1;
    end
  end

  assign fetch_count = fetchCount_q;
`else
  assign fetch_count = 32'd0;
`endif

endmodule

// File: doc/cu_if.md
Name: cu_if

Overview:
Instruction fetch stage of the control unit. It sits directly upstream of the decode stage.
- Holds the program counter (PC).
- Fetches one 32-bit instruction word at a time over a req/ack memory handshake.
- Presents the word on `instruction` and asserts `Fetch_ready`. These outputs drive the decode stage's instruction and decode-start inputs.
- Advances the PC by the decoder's `pc_increment`, or redirects to a CU-supplied target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ACK_TIMEOUT, 16, number of cycles in MEM without `mem_ack` before a timeout fault. 0 disables the timeout.

Ports:
- soc_clk  in  1  system clock; all state changes on the rising edge.
- IFU_reset  in  1  asynchronous, active-low reset.
- fetch_enable  in  1  leave IDLE and start fetching.
- IFU_stall  in  1  pipeline hazard stall.
- pc_advance  in  1  CU: current instruction retired, fetch the next one.
- pc_increment  in  32  signed PC offset from the decoder.
- redirect  in  1  CU branch/jump/flush.
- redirect_target  in  32  new PC when `redirect`=1.
- mem_req  out  1  instruction memory request.
- mem_addr  out  32  request address; equals `pc`.
- mem_ack  in  1  memory data valid.
- mem_rdata  in  32  instruction word.
- instruction  out  32  fetched instruction register.
- Fetch_ready  out  1  `instruction` valid; decode start.
- pc  out  32  PC of the current or pending fetch.
- fetch_fault  out  1  sticky fault flag.
- fault_cause  out  2  01 = misaligned PC, 10 = ack timeout.
- fetch_count  out  32  count of issued instructions (see Optional Feature).

Behaviour:
- Reset (`IFU_reset`=0, asynchronous, any state, including mid-request):
  - state=IDLE, pc=RESET_PC, instruction=0.
  - Fetch_ready=0, mem_req=0, fetch_fault=0, fault_cause=00.
  - fetch_count=0, timeout counter=0, discard flag=0.
  - An outstanding request is abandoned with no ack expected.
- FSM states: IDLE, MEM, ISSUE, WAIT, FAULT.
- IDLE:
  - If `fetch_enable`=1: when pc[1:0]≠00, go to FAULT with cause 01; otherwise go to MEM.
- MEM:
  - mem_req=1, mem_addr=pc; the timeout counter increments each cycle.
  - `mem_ack` may arrive in the first MEM cycle (zero-wait memory).
  - On `mem_ack` with discard=0: instruction<=mem_rdata, go to ISSUE. Minimum latency is 1 cycle from ack to `Fetch_ready`.
  - On `mem_ack` with discard=1: data dropped, discard<=0, pc<=latched target, stay in MEM for a new request. `Fetch_ready` is not asserted.
  - `redirect` in MEM: latch target, discard<=1. A later redirect before the ack overwrites the latched target.
  - `redirect` together with `mem_ack` in the same cycle: the data is dropped, pc<=redirect_target, stay in MEM.
  - If the counter reaches ACK_TIMEOUT (ACK_TIMEOUT≠0) without `mem_ack`: go to FAULT with cause 10.
  - The counter clears on leaving MEM or on a re-request.
  - `IFU_stall` has no effect in MEM.
- ISSUE:
  - Fetch_ready=1.
  - Stay while `IFU_stall`=1, so `Fetch_ready` stays high; otherwise go to WAIT.
  - `redirect` in ISSUE overrides: pc<=redirect_target and go to MEM. The CU squashes the already-signalled instruction.
- WAIT:
  - Fetch_ready=0; holds `instruction`.
  - Priority:
    1. `redirect`: next PC = redirect_target.
    2. `pc_advance` while `IFU_stall`=0: next PC = pc+pc_increment (32-bit modular wrap; 0xFFFFFFFC+4 = 0).
  - Otherwise hold.
  - `pc_advance` during `IFU_stall` is ignored, not queued.
  - The next PC is checked for alignment: when next_pc[1:0]≠00, pc<=next_pc and go to FAULT with cause 01. Otherwise pc<=next_pc and go to MEM.
- FAULT:
  - fetch_fault=1, mem_req=0, Fetch_ready=0.
  - Inputs are ignored; only reset exits.
- Outputs are registered, except `mem_addr` (equals `pc`) and `mem_req`/`Fetch_ready`, which are decoded from the state.
- `fetch_enable` is sampled only in IDLE.

Optional Feature:
- IFU_FETCH_COUNT_EN defined: `fetch_count` increments by 1 on each ISSUE entry; wraps at 2^32. A stall does not re-count, and discarded data is not counted.
- Not defined: `fetch_count` is tied to 0 and no counter logic is built.

Test Plan:
- Normal fetch:
  - Stimulus: RESET_PC=0, fetch_enable=1, mem_ack 2 cycles after mem_req with mem_rdata=0x00500093.
  - Required: mem_addr=0x0; instruction=0x00500093; Fetch_ready high exactly 1 cycle; then WAIT.
- Advance and zero-wait memory:
  - Stimulus: in WAIT, pc_advance with pc_increment=4; then pc_advance with pc_increment=0xFFFFFFF8 (-8); mem_ack given combinationally.
  - Required: mem_addr=0x4 then 0x4+(-8)=0xFFFFFFFC; Fetch_ready 1 cycle after each ack.
- Redirect during MEM:
  - Stimulus: redirect with target 0x100 during MEM; ack returns 0xDEADBEEF.
  - Required: data discarded, no Fetch_ready, mem_addr=0x100, next ack data issued.
- Misaligned PC:
  - Stimulus: pc=0x4, pc_advance with pc_increment=2.
  - Required: pc=0x6, fetch_fault=1, fault_cause=01, mem_req stays 0 until reset.
- Ack timeout:
  - Stimulus: no mem_ack for ACK_TIMEOUT=16 cycles.
  - Required: FAULT after the 16th MEM cycle, fault_cause=10, mem_req=0.
  - Stimulus: async reset mid-request.
  - Required: pc=RESET_PC, all outputs at reset values immediately.
- Stall handling:
  - Stimulus: IFU_stall held 3 cycles on ISSUE entry.
  - Required: Fetch_ready high 4 cycles; fetch_count +1 only (with IFU_FETCH_COUNT_EN).
  - Stimulus: pc_advance while stalled in WAIT.
  - Required: ignored, pc unchanged.
